// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Shared types and constants for the architectural register file slice.
//   REG_BITS          width of an architectural register index (5)
//   NREG              number of architectural registers (32, x0 hardwired)
//   XLEN              data width (32)
//   ROB_BITS_DEFAULT  default width of a reorder-buffer tag
//   ZERO_REG          index of the hardwired-zero register
//   is_zero_reg()     true when an index names x0
// -----------------------------------------------------------------------------
package register_file_pkg;

  localparam int REG_BITS         = 5;
  localparam int NREG             = 32;
  localparam int XLEN             = 32;
  localparam int ROB_BITS_DEFAULT = 4;

  typedef logic [REG_BITS-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]     word_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

  // x0 is never written, never renamed and always reads as zero.
  function automatic logic is_zero_reg(input reg_idx_t idx);
    return (idx == ZERO_REG);
  endfunction

endpackage

// File: rtl/register_file_if.sv
// -----------------------------------------------------------------------------
// register_file_if
// Issue/commit bus of the register file.
//   Parameter ROB_BITS : width of a reorder-buffer tag.
//   Read ports  : rs1_in/rs2_in index -> rsX_value / rsX_busy / rsX_tag
//   Rename port : rename_valid, rename_rd, rename_tag
//   Commit port : commit_valid, commit_rd, commit_tag, commit_value
// Modports:
//   master : issue + RoB side (drives indices, rename and commit; reads operands)
//   slave  : register file side
// -----------------------------------------------------------------------------
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int ROB_BITS = ROB_BITS_DEFAULT
) ();

  reg_idx_t            rs1_in;
  reg_idx_t            rs2_in;
  word_t               rs1_value;
  logic                rs1_busy;
  logic [ROB_BITS-1:0] rs1_tag;
  word_t               rs2_value;
  logic                rs2_busy;
  logic [ROB_BITS-1:0] rs2_tag;

  logic                rename_valid;
  reg_idx_t            rename_rd;
  logic [ROB_BITS-1:0] rename_tag;

  logic                commit_valid;
  reg_idx_t            commit_rd;
  logic [ROB_BITS-1:0] commit_tag;
  word_t               commit_value;

  modport master (
    output rs1_in, rs2_in,
    output rename_valid, rename_rd, rename_tag,
    output commit_valid, commit_rd, commit_tag, commit_value,
    input  rs1_value, rs1_busy, rs1_tag,
    input  rs2_value, rs2_busy, rs2_tag
  );

  modport slave (
    input  rs1_in, rs2_in,
    input  rename_valid, rename_rd, rename_tag,
    input  commit_valid, commit_rd, commit_tag, commit_value,
    output rs1_value, rs1_busy, rs1_tag,
    output rs2_value, rs2_busy, rs2_tag
  );

endinterface

// File: rtl/register_file_read_port.sv
// -----------------------------------------------------------------------------
// register_file_read_port
// One operand read port of the register file: index mux over the storage
// arrays, x0 forced to zero, and an optional commit-to-read forward.
// Configuration macro: REGFILE_COMMIT_BYPASS_EN
//   defined   : a read of the register being committed this cycle returns
//               commit_value / busy 0 / pre-commit tag (0 when not busy)
//   undefined : reads always reflect registered state
// Ports:
//   rdy                  stall qualifier for the forward
//   rs                   register index
//   values/busy/tags     registered storage arrays
//   commit_*             commit port, used only by the forward
//   rd_value/rd_busy/rd_tag  operand outputs (combinational)
// -----------------------------------------------------------------------------
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int ROB_BITS = ROB_BITS_DEFAULT
) (
  input  logic                          rdy,
  input  reg_idx_t                      rs,
  input  word_t [NREG-1:0]              values,
  input  logic  [NREG-1:0]              busy,
  input  logic  [NREG-1:0][ROB_BITS-1:0] tags,
  input  logic                          commit_valid,
  input  reg_idx_t                      commit_rd,
  input  logic  [ROB_BITS-1:0]          commit_tag,
  input  word_t                         commit_value,
  output word_t                         rd_value,
  output logic                          rd_busy,
  output logic  [ROB_BITS-1:0]          rd_tag
);

  word_t               reg_value_s;
  logic                reg_busy_s;
  logic [ROB_BITS-1:0] reg_tag_s;
  logic                fwd_s;

  // Raw lookup of the stored entry.
  always_comb begin
    reg_value_s = values[rs];
    reg_busy_s  = busy[rs];
    reg_tag_s   = tags[rs];
  end

`ifdef REGFILE_COMMIT_BYPASS_EN
  // Forward only a commit that would actually retire into this register:
  // either nothing is pending, or the pending tag is the committing one.
  always_comb begin
    if (rdy && commit_valid && !is_zero_reg(commit_rd) && (rs == commit_rd) &&
        (!reg_busy_s || (reg_tag_s == commit_tag))) begin
      fwd_s = 1'b1;
    end else begin
      fwd_s = 1'b0;
    end
  end
`else
  logic unused_bypass_s;

  // The commit port only feeds the forward, which is compiled out here.
  always_comb begin
    fwd_s           = 1'b0;
    unused_bypass_s = ^{rdy, commit_valid, commit_rd, commit_tag, commit_value};
  end
`endif

  // Output select: x0 zero, forwarded commit, or stored state.
  always_comb begin
    rd_value = {XLEN{1'b0}};
    rd_busy  = 1'b0;
    rd_tag   = {ROB_BITS{1'b0}};
    if (is_zero_reg(rs)) begin
      rd_value = {XLEN{1'b0}};
      rd_busy  = 1'b0;
      rd_tag   = {ROB_BITS{1'b0}};
    end else if (fwd_s) begin
      // Busy reads 0 even if issue renames this rd in the same cycle; the
      // reader consumes the committed value, not the new producer.
      rd_value = commit_value;
      rd_busy  = 1'b0;
      rd_tag   = reg_busy_s ? reg_tag_s : {ROB_BITS{1'b0}};
    end else begin
      rd_value = reg_value_s;
      rd_busy  = reg_busy_s;
      rd_tag   = reg_tag_s;
    end
  end

endmodule

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// Architectural register file with rename tags. Issue reads two operands and
// renames its destination; the reorder buffer commit port writes retired
// values and releases the rename; a RoB clear drops every pending rename.
// Configuration macro: REGFILE_COMMIT_BYPASS_EN (see register_file_read_port).
// Ports:
//   clk_in    system clock
//   rst_in    asynchronous active-high reset (values, busy and tags to 0)
//   rdy_in    global stall when low; state holds, reads stay live
//   clear_in  RoB flush: clears every busy/tag, suppresses rename, commit
//             still writes its value
//   bus       register_file_if.slave (read, rename and commit ports)
// -----------------------------------------------------------------------------
module register_file
  import register_file_pkg::*;
#(
  parameter int ROB_BITS = ROB_BITS_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  register_file_if.slave    bus
);

  word_t [NREG-1:0]               value_r;
  logic  [NREG-1:0]               busy_r;
  logic  [NREG-1:0][ROB_BITS-1:0] tag_r;

  logic commit_en_s;
  logic rename_en_s;
  logic release_s;

  // Qualify the commit and rename requests for this cycle.
  always_comb begin
    commit_en_s = rdy_in && bus.commit_valid && !is_zero_reg(bus.commit_rd);
    rename_en_s = rdy_in && bus.rename_valid && !is_zero_reg(bus.rename_rd) && !clear_in;
    // A stale tag means a younger op has re-renamed rd; keep it busy.
    // A same-cycle rename of the same rd also keeps it busy.
    if (commit_en_s && (tag_r[bus.commit_rd] == bus.commit_tag) &&
        !(rename_en_s && (bus.rename_rd == bus.commit_rd))) begin
      release_s = 1'b1;
    end else begin
      release_s = 1'b0;
    end
  end

  // Storage update: commit value write, busy release, rename, flush.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      value_r <= '0;
      busy_r  <= '0;
      tag_r   <= '0;
    end else if (rdy_in) begin
      // The value is written even on a stale tag or during a flush.
      if (commit_en_s) begin
        value_r[bus.commit_rd] <= bus.commit_value;
      end
      if (clear_in) begin
        busy_r <= '0;
        tag_r  <= '0;
      end else begin
        if (release_s) begin
          busy_r[bus.commit_rd] <= 1'b0;
        end
        // Issued after the commit in program order, so rename wins.
        if (rename_en_s) begin
          busy_r[bus.rename_rd] <= 1'b1;
          tag_r[bus.rename_rd]  <= bus.rename_tag;
        end
      end
    end
  end

  register_file_read_port #(.ROB_BITS(ROB_BITS)) u_rs1_port (
    .rdy          (rdy_in),
    .rs           (bus.rs1_in),
    .values       (value_r),
    .busy         (busy_r),
    .tags         (tag_r),
    .commit_valid (bus.commit_valid),
    .commit_rd    (bus.commit_rd),
    .commit_tag   (bus.commit_tag),
    .commit_value (bus.commit_value),
    .rd_value     (bus.rs1_value),
    .rd_busy      (bus.rs1_busy),
    .rd_tag       (bus.rs1_tag)
  );

  register_file_read_port #(.ROB_BITS(ROB_BITS)) u_rs2_port (
    .rdy          (rdy_in),
    .rs           (bus.rs2_in),
    .values       (value_r),
    .busy         (busy_r),
    .tags         (tag_r),
    .commit_valid (bus.commit_valid),
    .commit_rd    (bus.commit_rd),
    .commit_tag   (bus.commit_tag),
    .commit_value (bus.commit_value),
    .rd_value     (bus.rs2_value),
    .rd_busy      (bus.rs2_busy),
    .rd_tag       (bus.rs2_tag)
  );

endmodule
